// File: rtl/mmio_uart_responder_if.sv
// Core data-bus port of the MMIO UART responder: read strobe, byte write enables,
// address and write data from the core, combinational read data back.
interface mmio_uart_responder_if;
    // Strobe semantics: r and w are sampled every cycle and never both set.
    // A write commits at the posedge, and out answers r in the same cycle.
    logic        r;
    logic [3:0]  w;
    logic [31:0] addr;
    logic [31:0] in;
    logic [31:0] out;

    modport master (output r, w, addr, in, input out);
    modport slave  (input r, w, addr, in, output out);
endinterface

// File: rtl/mmio_uart_responder.sv
// MMIO responder next to RAM: byte TX FIFO feeding an 8N1 UART, a free-running
// cycle counter and a sticky exit/halt register, all in one 16-byte window.
module mmio_uart_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_uart_responder_if.slave  bus,
    output logic                  tx,
    output logic                  halt,
    output logic [7:0]            exit_code,
    output logic [1:0]            fsm_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          sel;
    logic          wr;
    logic [1:0]    off;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          busy;
    logic          ovf_clr;
    logic          exit_wr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic [31:0]   cycle_q;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          div_last;

    logic          unused;
    assign unused = ^{bus.in[31:8], bus.addr[1:0]};

    assign sel      = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign off      = bus.addr[3:2];
    assign wr       = sel && (|bus.w);
    assign push_req = wr && (off == 2'd0) && bus.w[0];
    assign ovf_clr  = wr && (off == 2'd1) && bus.w[0] && bus.in[2];
    assign exit_wr  = wr && (off == 2'd3) && bus.w[0];

    // full is taken before any same-cycle pop, so a push into a full FIFO is
    // always dropped even while the FSM is freeing a slot.
    assign full = (count_q == CW'(FIFO_DEPTH));
    assign push = push_req && !full;
    assign pop  = (state_q == IDLE) && (count_q != '0);
    assign busy = (state_q != IDLE) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= bus.in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cycle_q   <= '0;
            halt      <= 1'b0;
            exit_code <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req && full) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            if (exit_wr) begin
                exit_code <= bus.in[7:0];
                halt      <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign div_last = (div_q == DW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    shreg_d = mem[rptr_q];
                    state_d = START;
                    div_d   = '0;
                end
            end
            START: begin
                if (div_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DATA: begin
                if (div_last) begin
                    div_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            STOP: begin
                if (div_last) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is precomputed from next state so the line flop changes with the FSM.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx        = tx_q;
    assign fsm_state = state_q;

    always_comb begin
        bus.out = '0;
        if (sel && bus.r) begin
            case (off)
                2'd1:    bus.out = {29'b0, ovf_q, busy, full};
                2'd2:    bus.out = cycle_q;
                2'd3:    bus.out = {24'b0, exit_code};
                default: bus.out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Bench for mmio_uart_responder: register vectors from a table, UART frames
// decoded by a monitor and compared against a queue of expected bytes.
module tb_mmio_uart_responder;

    localparam logic [31:0] TXDATA = 32'h8000_0000;
    localparam logic [31:0] STATUS = 32'h8000_0004;
    localparam logic [31:0] CYCLE  = 32'h8000_0008;
    localparam logic [31:0] EXIT   = 32'h8000_000C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx;
    logic       halt;
    logic [7:0] exit_code;
    logic [1:0] fsm_state;

    int checks    = 0;
    int failures  = 0;
    int rst_count = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic        r;
        logic [3:0]  w;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_out;
        logic        exp_halt;
        logic [7:0]  exp_exit;
    } vec_t;

    vec_t vecs[14];

    mmio_uart_responder_if bus();

    mmio_uart_responder #(
        .BASE_ADDR   (32'h8000_0000),
        .FIFO_DEPTH  (4),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .tx       (tx),
        .halt     (halt),
        .exit_code(exit_code),
        .fsm_state(fsm_state)
    );

    // clock / reset bookkeeping
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) rst_count++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    // driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rr, input logic [3:0] ww, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.r    = rr;
        bus.w    = ww;
        bus.addr = a;
        bus.in   = d;
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        drive(1'b0, 4'b0001, TXDATA, {24'h0, b});
        if (accepted) exp_q.push_back(b);
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 4'b0000, a, 32'h0);
        check(name, bus.out, exp);
    endtask

    task automatic wait_tx_fall(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            bus.r = 1'b0;
            bus.w = 4'b0000;
            lat++;
        end while (tx !== 1'b0 && lat < 64);
        if (tx !== 1'b0) check("tx_fall_timeout", {31'h0, tx}, 32'h0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            drive(1'b1, 4'b0000, STATUS, 32'h0);
            n++;
        end while (bus.out[1] !== 1'b0 && n < 2000);
        check(name, bus.out, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        bus.r = 1'b0;
        bus.w = 4'b0000;
        @(negedge clk);
        rst      = 1'b0;
        bus.r    = 1'b1;
        bus.addr = CYCLE;
        #1;
        check("cycle_after_reset", bus.out, 32'h0);
        check("tx_after_reset", {31'h0, tx}, 32'h1);
        check("halt_after_reset", {31'h0, halt}, 32'h0);
        check("exit_after_reset", {24'h0, exit_code}, 32'h0);
        exp_q.delete();
    endtask

    // scoreboard: decode 8N1 frames mid-bit and pop the expected byte
    initial begin
        logic [7:0] b;
        int rc;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                rc = rst_count;
                repeat (6) @(negedge clk);
                b[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                if (rc == rst_count) begin
                    check("stop_bit", {31'h0, tx}, 32'h1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got byte %h expected none", b);
                    end else begin
                        check("rx_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        logic [31:0] v0, v1, v2;
        int lat;
        bit hi;

        bus.r = 1'b0; bus.w = 4'b0000; bus.addr = 32'h0; bus.in = 32'h0;
        repeat (3) @(negedge clk);
        do_reset();

        // reset state and counter
        read_chk("status_reset", STATUS, 32'h0);
        check("tx_idle", {31'h0, tx}, 32'h1);
        drive(1'b1, 4'b0000, CYCLE, 32'h0); v0 = bus.out;
        drive(1'b1, 4'b0000, CYCLE, 32'h0); v1 = bus.out;
        drive(1'b1, 4'b0000, CYCLE, 32'h0); v2 = bus.out;
        check("cycle_plus1", v1, v0 + 32'd1);
        check("cycle_plus2", v2, v0 + 32'd2);

        // single frame 0x55
        push_byte(8'h55, 1'b1);
        wait_tx_fall(lat);
        check("frame_latency", lat, 32'd2);
        repeat (19) @(negedge clk);
        drive(1'b1, 4'b0000, STATUS, 32'h0);
        check("busy_mid_frame", bus.out, 32'h2);
        repeat (19) @(negedge clk);
        drive(1'b1, 4'b0000, STATUS, 32'h0);
        check("busy_after_frame", bus.out, 32'h0);
        check("tx_after_frame", {31'h0, tx}, 32'h1);

        // back-to-back frames with one idle cycle between
        push_byte(8'h41, 1'b1);
        push_byte(8'h42, 1'b1);
        wait_tx_fall(lat);
        repeat (39) @(negedge clk);
        check("stop_before_gap", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("gap_high", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("second_start", {31'h0, tx}, 32'h0);
        wait_idle("drain_b2b");

        // overflow: first pop frees a slot, sixth push dropped
        for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i), i < 5);
        read_chk("status_full_ovf", STATUS, 32'h7);
        drive(1'b0, 4'b0001, STATUS, 32'h4);
        read_chk("status_ovf_clr", STATUS, 32'h3);
        wait_idle("drain_ovf");

        // register vectors: exit/halt, window decode, read data gating
        vecs[0]  = '{1'b1, 4'b0000, STATUS,        32'h0,   32'h0,  1'b0, 8'h00};
        vecs[1]  = '{1'b1, 4'b0000, TXDATA,        32'h0,   32'h0,  1'b0, 8'h00};
        vecs[2]  = '{1'b1, 4'b0000, EXIT,          32'h0,   32'h0,  1'b0, 8'h00};
        vecs[3]  = '{1'b1, 4'b0000, 32'h0000_100C, 32'h0,   32'h0,  1'b0, 8'h00};
        vecs[4]  = '{1'b0, 4'b0010, EXIT,          32'h2A,  32'h0,  1'b0, 8'h00};
        vecs[5]  = '{1'b1, 4'b0000, EXIT,          32'h0,   32'h0,  1'b0, 8'h00};
        vecs[6]  = '{1'b0, 4'b0001, 32'h0000_100C, 32'h99,  32'h0,  1'b0, 8'h00};
        vecs[7]  = '{1'b1, 4'b0000, EXIT,          32'h0,   32'h0,  1'b0, 8'h00};
        vecs[8]  = '{1'b0, 4'b0001, EXIT,          32'h2A,  32'h0,  1'b0, 8'h00};
        vecs[9]  = '{1'b1, 4'b0000, EXIT,          32'h0,   32'h2A, 1'b1, 8'h2A};
        vecs[10] = '{1'b1, 4'b0000, 32'h8000_000F, 32'h0,   32'h2A, 1'b1, 8'h2A};
        vecs[11] = '{1'b0, 4'b0001, EXIT,          32'h107, 32'h0,  1'b1, 8'h2A};
        vecs[12] = '{1'b1, 4'b0000, EXIT,          32'h0,   32'h7,  1'b1, 8'h07};
        vecs[13] = '{1'b1, 4'b0000, 32'h8001_000C, 32'h0,   32'h0,  1'b1, 8'h07};
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].din);
            check($sformatf("vec%0d_out", i), bus.out, vecs[i].exp_out);
            check($sformatf("vec%0d_halt", i), {31'h0, halt}, {31'h0, vecs[i].exp_halt});
            check($sformatf("vec%0d_exit", i), {24'h0, exit_code}, {24'h0, vecs[i].exp_exit});
        end

        // TX keeps draining after halt
        push_byte(8'h3C, 1'b1);
        wait_idle("drain_after_halt");

        // reset during DATA bit 3
        push_byte(8'hA5, 1'b1);
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        wait_tx_fall(lat);
        repeat (15) @(negedge clk);
        do_reset();
        read_chk("status_after_rst", STATUS, 32'h0);
        hi = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) hi = 1'b0;
        end
        check("no_resume", {31'h0, hi}, 32'h1);

        // accesses outside the window
        drive(1'b0, 4'b1111, 32'h0000_1000, 32'hA5);
        drive(1'b0, 4'b0001, 32'h0000_1004, 32'h4);
        drive(1'b0, 4'b0001, 32'h0000_100C, 32'h55);
        read_chk("outside_read0", 32'h0000_1000, 32'h0);
        read_chk("outside_read4", 32'h0000_1004, 32'h0);
        hi = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (tx !== 1'b1) hi = 1'b0;
        end
        check("outside_tx_idle", {31'h0, hi}, 32'h1);
        read_chk("outside_status", STATUS, 32'h0);
        check("outside_halt", {31'h0, halt}, 32'h0);
        check("exp_q_empty", exp_q.size(), 32'h0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
